// File: rtl/demux_32_bit_3_op.sv
// demux_32_bit_3_op: routes one input word to one of three lanes by in_sel.
// Each lane buffers up to two words in its own FIFO. Words sent with
// in_sel==11 are always accepted, then dropped, and they set the sticky
// err_sel flag.
// Optional feature: define DEMUX_DROP_CNT_EN to add the 8-bit saturating
// drop_cnt output, which counts dropped words.

// Per-lane 2-entry FIFO. The caller never pushes when full and never pops
// when empty.
module demux_lane_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  // Storage, 1-bit pointers that wrap 1->0, occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == 2'd2);
  assign valid = (count != 2'd0);
  // An empty lane shows zero, not the stale entry.
  assign head  = valid ? mem[rd_ptr] : '0;
endmodule

module demux_32_bit_3_op #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [2:0]         out_valid,
  input  logic [2:0]         out_ready,
  output logic [3*WIDTH-1:0] out_data,
  output logic               err_sel,
`ifdef DEMUX_DROP_CNT_EN
  output logic [7:0]         drop_cnt,
`endif
  input  logic               err_clr
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0]            lane_full;
  logic [NUM_LANES-1:0]            lane_push;
  logic [NUM_LANES-1:0]            lane_pop;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_head;
  logic                            accept;
  logic                            drop;

  // Ready depends only on the selected lane's fullness and never on out_ready.
  // Illegal selects are always taken so the producer cannot stall on them.
  always_comb begin
    in_ready = 1'b0;
    if (reset_n) begin
      if (in_sel == 2'b11) in_ready = 1'b1;
      else                 in_ready = ~lane_full[in_sel];
    end
  end

  assign accept   = in_valid & in_ready;
  assign drop     = accept & (in_sel == 2'b11);
  assign lane_pop = out_valid & out_ready;
  assign out_data = lane_head;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_push[k] = accept & (in_sel == 2'(k));

    demux_lane_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (lane_push[k]),
      .pop     (lane_pop[k]),
      .wdata   (in_data),
      .full    (lane_full[k]),
      .valid   (out_valid[k]),
      .head    (lane_head[k])
    );
  end

  // Sticky illegal-select flag. When a set and a clear land on the same
  // edge, the set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err_sel <= 1'b0;
    else if (drop)    err_sel <= 1'b1;
    else if (err_clr) err_sel <= 1'b0;
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating drop counter. A drop on the same edge as a clear restarts
  // the count at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        drop_cnt <= 8'd0;
    else if (drop && err_clr)            drop_cnt <= 8'd1;
    else if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    else if (err_clr)                    drop_cnt <= 8'd0;
  end
`endif
endmodule

// File: tb/tb_demux_32_bit_3_op.sv
// Directed bench for demux_32_bit_3_op. Inputs change 1 time unit after the
// rising edge, and outputs are sampled at that same point.
module tb_demux_32_bit_3_op;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [95:0] out_data;
  logic        err_sel;
  logic        err_clr;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  demux_32_bit_3_op #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_sel   (err_sel),
`ifdef DEMUX_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane(input int k);
    return out_data[k*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'b00;
    out_ready = 3'b000; err_clr = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL reset_out_valid got=%b exp=000", out_valid); end
    checks++; if (out_data !== 96'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (err_sel !== 1'b0) begin failures++; $display("FAIL reset_err_sel got=%b exp=0", err_sel); end
`ifdef DEMUX_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  // This push is taken on the first edge after reset release.
  task automatic test_single();
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'hAAAA5555;
    tick();
    in_valid = 1'b0; in_data = 32'hDEADBEEF;
    checks++; if (out_valid !== 3'b010) begin failures++; $display("FAIL single_valid got=%b exp=010", out_valid); end
    checks++; if (out_data !== {32'h0, 32'hAAAA5555, 32'h0}) begin failures++; $display("FAIL single_data got=%h exp=%h", out_data, {32'h0, 32'hAAAA5555, 32'h0}); end
    out_ready = 3'b010;
    tick();
    out_ready = 3'b000;
    checks++; if (out_valid !== 3'b000 || out_data !== 96'd0) begin failures++; $display("FAIL single_pop got=%b/%h exp=000/0", out_valid, out_data); end
  endtask

  task automatic test_full_lane2();
    out_ready = 3'b000; in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h1;
    #0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_rdy1 got=%b exp=1", in_ready); end
    tick();
    in_data = 32'h2;
    tick();
    in_data = 32'h3;
    #0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_rdy3 got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 3'b100 || lane(2) !== 32'h1) begin failures++; $display("FAIL full_head1 got=%b/%h exp=100/1", out_valid, lane(2)); end
    out_ready = 3'b100;
    #0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru got=%b exp=0", in_ready); end
    tick();
    checks++; if (lane(2) !== 32'h2 || in_ready !== 1'b1) begin failures++; $display("FAIL full_head2 got=%h/%b exp=2/1", lane(2), in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 3'b100 || lane(2) !== 32'h3) begin failures++; $display("FAIL full_head3 got=%b/%h exp=100/3", out_valid, lane(2)); end
    tick();
    out_ready = 3'b000;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL full_drain got=%b exp=000", out_valid); end
  endtask

  // Push and pop on the same edge with one word held: count stays at 1.
  task automatic test_push_pop();
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h10;
    tick();
    checks++; if (out_valid !== 3'b001 || lane(0) !== 32'h10) begin failures++; $display("FAIL pp_head10 got=%b/%h exp=001/10", out_valid, lane(0)); end
    in_data = 32'h11; out_ready = 3'b001;
    tick();
    in_valid = 1'b0; out_ready = 3'b000;
    checks++; if (out_valid !== 3'b001 || lane(0) !== 32'h11) begin failures++; $display("FAIL pp_head11 got=%b/%h exp=001/11", out_valid, lane(0)); end
    out_ready = 3'b001;
    tick();
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL pp_count1 got=%b exp=000", out_valid); end
    // out_ready on an empty lane does nothing.
    tick();
    out_ready = 3'b000;
    checks++; if (out_valid !== 3'b000 || out_data !== 96'd0) begin failures++; $display("FAIL pp_empty_pop got=%b/%h exp=000/0", out_valid, out_data); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b0; in_sel = 2'b11; in_data = 32'hFFFFFFFF;
    tick();
    checks++; if (err_sel !== 1'b0) begin failures++; $display("FAIL ill_idle_sel got=%b exp=0", err_sel); end
    in_valid = 1'b1;
    #0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (err_sel !== 1'b1 || out_valid !== 3'b000 || out_data !== 96'd0) begin failures++; $display("FAIL ill_drop got=%b/%b/%h exp=1/000/0", err_sel, out_valid, out_data); end
`ifdef DEMUX_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL ill_cnt got=%0d exp=1", drop_cnt); end
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_sel !== 1'b0) begin failures++; $display("FAIL ill_clr got=%b exp=0", err_sel); end
`ifdef DEMUX_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL ill_cnt_clr got=%0d exp=0", drop_cnt); end
`endif
    in_valid = 1'b1; err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    checks++; if (err_sel !== 1'b1) begin failures++; $display("FAIL ill_set_wins got=%b exp=1", err_sel); end
`ifdef DEMUX_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL ill_cnt_wins got=%0d exp=1", drop_cnt); end
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Order is kept within a lane while pushes to other lanes are interleaved.
  task automatic test_order();
    in_valid = 1'b1;
    in_sel = 2'b01; in_data = 32'hA1; tick();
    in_sel = 2'b00; in_data = 32'hB1; tick();
    in_sel = 2'b01; in_data = 32'hA2; tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 3'b011 || lane(1) !== 32'hA1 || lane(0) !== 32'hB1) begin failures++; $display("FAIL ord_heads got=%b/%h/%h exp=011/a1/b1", out_valid, lane(1), lane(0)); end
    out_ready = 3'b010;
    tick();
    out_ready = 3'b000;
    checks++; if (lane(1) !== 32'hA2 || lane(0) !== 32'hB1) begin failures++; $display("FAIL ord_second got=%h/%h exp=a2/b1", lane(1), lane(0)); end
  endtask

  // Lanes 0 and 1 still hold words from the previous task. This reset is
  // asynchronous and arrives between edges.
  task automatic test_async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b000 || out_data !== 96'd0) begin failures++; $display("FAIL arst_now got=%b/%h exp=000/0", out_valid, out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (out_valid !== 3'b000 || out_data !== 96'd0) begin failures++; $display("FAIL arst_stale got=%b/%h exp=000/0", out_valid, out_data); end
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hC0;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 3'b001 || lane(0) !== 32'hC0) begin failures++; $display("FAIL arst_fresh got=%b/%h exp=001/c0", out_valid, lane(0)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_lane2();
    test_push_pop();
    test_illegal();
    test_order();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_32_bit_3_op.md
DEMUX_32_BIT_3_OP -- requirements
Module: demux_32_bit_3_op

Interface
REQ-001 Parameter: WIDTH, 32, data width of the input word and of each output lane.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  producer presents a word.
REQ-005 Port: in_ready  output  1  block accepts the word this cycle.
REQ-006 Port: in_data  input  WIDTH  word to route.
REQ-007 Port: in_sel  input  2  destination: 00 lane 0, 01 lane 1, 10 lane 2, 11 illegal.
REQ-008 Port: out_valid  output  3  bit k high: lane k head word valid.
REQ-009 Port: out_ready  input  3  bit k high: consumer k takes lane k head.
REQ-010 Port: out_data  output  3*WIDTH  lane k head word at bits [WIDTH*k+WIDTH-1 : WIDTH*k].
REQ-011 Port: err_sel  output  1  sticky flag, illegal-select word dropped.
REQ-012 Port: err_clr  input  1  synchronous clear of err_sel (and drop_cnt when compiled in).

Function
REQ-013 Each lane SHALL own an independent 2-entry FIFO (write ptr, read ptr, 2-bit occupancy count, pointers wrap 1->0).
REQ-014 Accept (push) SHALL occur when in_valid and in_ready are both high at a clock edge; word goes to the FIFO of lane in_sel.
REQ-015 in_ready SHALL be combinational: 1 when in_sel==11; otherwise NOT full of lane in_sel; independent of out_ready (no ready pass-through).
REQ-016 in_ready SHALL be 0 while reset_n is low.
REQ-017 out_valid[k] SHALL equal (count_k != 0); out_data lane k SHALL show the FIFO head; lane k data when empty SHALL be 0.
REQ-018 Pop SHALL occur on lane k when out_valid[k] and out_ready[k] are high at a clock edge.
REQ-019 Latency: word pushed into an empty lane SHALL appear on out_valid/out_data of that lane on the following cycle.
REQ-020 Simultaneous push and pop on the same lane with count 1 SHALL leave count 1 and head advance to the new word; with count 2 no push occurs (in_ready low).
REQ-021 Pop on an empty lane and out_ready on any lane SHALL have no effect when out_valid is low.
REQ-022 Per-lane word order SHALL be preserved; no ordering relation between lanes.
REQ-023 An accepted word with in_sel==11 SHALL be discarded and set err_sel on the next edge.
REQ-024 err_clr high at an edge SHALL clear err_sel; if an illegal word is accepted in the same cycle, set SHALL win.
REQ-025 in_data SHALL be ignored when no push occurs; in_sel changes while in_valid is low SHALL have no effect.

Reset
REQ-026 reset_n low SHALL immediately, without clock, empty all FIFOs (pointers and counts 0), drive out_valid=000, out_data=0, err_sel=0, drop_cnt=0.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered words; no word SHALL reappear after reset release.
REQ-028 First accept SHALL be possible at the first clock edge after reset_n rises.

Configuration
REQ-029 Macro DEMUX_DROP_CNT_EN defined: extra port drop_cnt  output  8  count of discarded illegal-select words, +1 per drop, saturating at 255, cleared by err_clr (increment wins over clear in same cycle, result 1).
REQ-030 Macro DEMUX_DROP_CNT_EN undefined: drop_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset, then in_sel=01, in_data=32'hAAAA5555, in_valid 1 cycle -> next cycle out_valid=010, lane 1 data 32'hAAAA5555, lanes 0/2 data 0.
REQ-032 out_ready=000, push 32'h1, 32'h2, 32'h3 to lane 2 -> first two accepted, in_ready low on third; then out_ready=100 -> lane 2 emits 1 then 2, then third accepted.
REQ-033 Lane 0 count 1 (head 32'h10), same cycle push 32'h11 to lane 0 and out_ready=001 -> count stays 1, head 32'h11.
REQ-034 in_sel=11, in_data=32'hFFFFFFFF accepted -> in_ready 1, out_valid unchanged, err_sel 1 (drop_cnt 1 when enabled); err_clr pulse -> err_sel 0, drop_cnt 0.
REQ-035 Both lanes 0 and 1 holding words, reset_n pulsed low between edges -> out_valid=000 immediately, all lane data 0, no stale word after release.
